// File: rtl/ram_256x32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_256x32_pkg
// Brief    : Shared geometry constants for the 256x32 single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
package ram_256x32_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

endpackage : ram_256x32_pkg
`default_nettype wire

// File: rtl/ram_256x32_core.sv
`default_nettype none
// ============================================================================
// Module   : ram_core
// Brief    : Reset-clearable register array, synchronous write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module ram_core
  import ram_256x32_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int DP = DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DP];
  logic [DW-1:0] r_dout;

  // Whole array clears on reset so stale data never survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DP; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (re) begin
      r_dout <= r_mem[raddr];
    end
  end

  assign rdata = r_dout;

endmodule : ram_core
`default_nettype wire

// File: rtl/ram_256x32.sv
`default_nettype none
// ============================================================================
// Module   : ram_256x32
// Brief    : 256x32 single-port synchronous RAM with tri-state read bus.
// Revision : 1.0 - initial release
// ============================================================================
module ram_256x32
  import ram_256x32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rw,
  input  logic [ADDR_W-1:0] adrs,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_rdata;

  // An unknown cs or rw yields an unknown strobe, which the core treats as idle.
  assign w_we = ~cs & rw;
  assign w_re = ~cs & ~rw;

  ram_core #(
    .DW (DATA_W),
    .AW (ADDR_W),
    .DP (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (adrs),
    .wdata (data_in),
    .re    (w_re),
    .raddr (adrs),
    .rdata (w_rdata)
  );

  assign data_out = w_re ? w_rdata : 'z;

endmodule : ram_256x32
`default_nettype wire

// File: tb/tb_ram_256x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_256x32
// Brief    : Self-checking bench for ram_256x32 against an array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_256x32;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        rw;
  logic [7:0]  adrs;
  logic [31:0] data_in;

  // Two identical devices, one on a pulled-up bus and one on a pulled-down
  // bus: all-ones on the first and all-zeros on the second means nobody drives.
  tri1 [31:0] bus_pu;
  tri0 [31:0] bus_pd;

  ram_256x32 dut_pu (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw),
    .adrs(adrs), .data_in(data_in), .data_out(bus_pu)
  );

  ram_256x32 dut_pd (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw),
    .adrs(adrs), .data_in(data_in), .data_out(bus_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [256];
  int checks = 0;
  int errors = 0;

  task automatic check_bus(input string tag, input bit exp_z, input logic [31:0] exp);
    logic [63:0] obs;
    logic [63:0] want;
    obs  = {bus_pu, bus_pd};
    want = exp_z ? {32'hFFFF_FFFF, 32'h0} : {exp, exp};
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed pu/pd=%h/%h expected %s", tag, obs[63:32], obs[31:0],
             exp_z ? "Z" : $sformatf("%h", exp));
    end
  endtask

  // One bus cycle: drive on the falling edge, check just after the rising edge.
  task automatic bus_cycle(input string tag, input logic c, input logic r,
                           input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = c; rw = r; adrs = a; data_in = d;
    @(posedge clk);
    #1;
    if (c == 1'b0 && r == 1'b1) model[a] = d;
    if (c == 1'b0 && r == 1'b0) check_bus(tag, 1'b0, model[a]);
    else                        check_bus(tag, 1'b1, 32'h0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
  endtask

  task automatic read_sweep(input string tag);
    for (int i = 0; i < 256; i++) bus_cycle(tag, 1'b0, 1'b0, 8'(i), 32'h0);
  endtask

  initial begin
    cs = 1'b1; rw = 1'b0; adrs = 8'h0; data_in = 32'h0;
    clear_model();

    // Reset, with a selected read so the output shows the cleared register.
    rst = 1'b1;
    #3;
    cs = 1'b0; rw = 1'b0;
    #1;
    check_bus("reset_out", 1'b0, 32'h0);
    cs = 1'b1;
    #1;
    check_bus("reset_desel_z", 1'b1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    read_sweep("reset_read");

    // Deselected: bus stays released, nothing is written.
    for (int i = 0; i < 256; i += 17) bus_cycle("desel_rd", 1'b1, 1'b0, 8'(i), 32'hDEADBEEF);
    for (int i = 0; i < 256; i++)     bus_cycle("desel_wr", 1'b1, 1'b1, 8'(i), 32'hDEADBEEF);
    read_sweep("desel_readback");

    // Random write sweep then readback.
    for (int i = 0; i < 256; i++) bus_cycle("wr_sweep", 1'b0, 1'b1, 8'(i), $urandom);
    read_sweep("rd_sweep");

    // Edge addresses.
    bus_cycle("edge_wr255", 1'b0, 1'b1, 8'd255, 32'hFFFF_FFFF);
    bus_cycle("edge_wr0",   1'b0, 1'b1, 8'd0,   32'h0000_0001);
    bus_cycle("edge_rd255", 1'b0, 1'b0, 8'd255, 32'h0);
    bus_cycle("edge_rd0",   1'b0, 1'b0, 8'd0,   32'h0);
    bus_cycle("edge_rd254", 1'b0, 1'b0, 8'd254, 32'h0);
    bus_cycle("edge_rd1",   1'b0, 1'b0, 8'd1,   32'h0);
    check_bus("edge_val0", 1'b0, (model[0] == 32'h1) ? bus_pd : 32'h1);

    // Overwrite on consecutive edges: last write wins, visible on the next read.
    bus_cycle("ovw_wr1", 1'b0, 1'b1, 8'h10, 32'hA5A5_A5A5);
    bus_cycle("ovw_wr2", 1'b0, 1'b1, 8'h10, 32'h5A5A_5A5A);
    bus_cycle("ovw_rd",  1'b0, 1'b0, 8'h10, 32'h0);
    assert (model[8'h10] == 32'h5A5A_5A5A) else begin
      errors++;
      $error("FAIL ovw_model observed %h expected 5a5a5a5a", model[8'h10]);
    end

    // Randomised mixed traffic.
    for (int n = 0; n < 400; n++) begin
      bus_cycle("rand_mix", 1'($urandom_range(0, 3) == 0), 1'($urandom),
                8'($urandom), $urandom);
    end

    // Address change only appears after the next edge.
    bus_cycle("lat_wr", 1'b0, 1'b1, 8'h20, 32'h1234_5678);
    bus_cycle("lat_rd", 1'b0, 1'b0, 8'h20, 32'h0);
    @(negedge clk);
    adrs = 8'h10;
    #1;
    check_bus("lat_hold", 1'b0, 32'h1234_5678);

    // Async reset in the middle of a read stream.
    @(posedge clk);
    #1;
    check_bus("pre_async", 1'b0, model[8'h10]);
    #2;
    rst = 1'b1;
    #1;
    check_bus("async_rst", 1'b0, 32'h0);
    clear_model();
    #1;
    rst = 1'b0;
    read_sweep("post_rst_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_ram_256x32
`default_nettype wire
